reg_view_scanner: RTL and testbench

Read-side companion of the processor register bank's display port. While the processor sits in its register-inspection state, the block selects one of the 16 registers over the 6-bit index bus, samples the returned 16-bit value, and drives six active-low seven-segment displays: four hex digits of value, two decimal digits of index. Debounced pushbuttons step through registers; an optional auto-scan mode steps on its own.

---
 rtl/reg_view_scanner.sv | 263 ++++++++++++++++++++++++++
 tb/tb_reg_view_scanner.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_view_scanner.sv
// Register bank viewer: steps an index over the bank and shows the value on six 7-segment digits.
// Latency: view_en -> value on display in 3 edges; key press event -> new value in 3 edges.
// Backpressure: none; press events outside SHOW are dropped, the bank read is combinational.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-low reset
//   view_en         processor is in the register-inspection state
//   key_next/prev   raw active-low pushbuttons (asynchronous, bouncing)
//   auto_sw         auto-scan select, only meaningful with REG_VIEW_AUTOSCAN_EN
//   chave/valor     6-bit index to the bank and the 16-bit value it returns
//   valid           displays currently show the value of the current index
//   hex0..hex3      value nibbles 3:0 .. 15:12, segments gfedcba, active-low
//   hex4/hex5       index units / tens in decimal
//
// Build option: define REG_VIEW_AUTOSCAN_EN to add the SCAN_DIV auto-step counter.

module reg_view_scanner #(
  parameter int DEBOUNCE = 250000,
  parameter int SCAN_DIV = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        view_en,
  input  logic        key_next,
  input  logic        key_prev,
  input  logic        auto_sw,
  output logic [5:0]  chave,
  input  logic [15:0] valor,
  output logic        valid,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SAMPLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  localparam logic [6:0] BLANK = 7'h7F;

  // Segment patterns for 0..F, gfedcba, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Key conditioning: index 0 = key_next, index 1 = key_prev.
  // ---------------------------------------------------------------------------
  logic [1:0]    key_raw;
  logic [1:0]    key_s1;
  logic [1:0]    key_s2;
  logic [1:0]    key_stable;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    press;

  assign key_raw = {key_prev, key_next};

  // The counter runs only while the synchronized level differs from the
  // accepted one; any sample that matches the accepted level restarts it,
  // so a bounce shorter than DEBOUNCE samples never gets through.
  always_ff @(posedge clock) begin
    if (!reset) begin
      key_s1     <= 2'b11;
      key_s2     <= 2'b11;
      key_stable <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          key_stable[i] <= key_s2[i];
          deb_cnt[i]    <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press is the cycle whose edge accepts a 1->0 change; it is a one-cycle
  // strobe because the accepted level flips at that same edge.
  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      press[i] = key_stable[i] && !key_s2[i] && (deb_cnt[i] == DEB_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Step decode
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [15:0] disp_val;
  logic [3:0]  disp_idx;
  logic        step_fwd;
  logic        step_bwd;
  logic        step_take;

`ifdef REG_VIEW_AUTOSCAN_EN
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic          scan_run;
  logic          scan_tick;

  assign scan_run  = (state == SHOW) && auto_sw;
  assign scan_tick = scan_run && view_en && (scan_cnt == SCAN_LAST);

  always_ff @(posedge clock) begin
    if (!reset || !scan_run || scan_tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // In auto mode the keys are ignored entirely; the counter is the only source.
  always_comb begin
    if (auto_sw) begin
      step_fwd = scan_tick;
      step_bwd = 1'b0;
    end else begin
      step_fwd = press[0] && !press[1];
      step_bwd = press[1] && !press[0];
    end
  end
`else
  logic unused_auto_sw;
  assign unused_auto_sw = auto_sw;

  // Both keys accepted on the same cycle cancel out.
  always_comb begin
    step_fwd = press[0] && !press[1];
    step_bwd = press[1] && !press[0];
  end
`endif

  // A step is only honoured from SHOW and never while view_en is falling.
  assign step_take = (state == SHOW) && view_en && (step_fwd || step_bwd);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (view_en) state_nxt = ISSUE;
      ISSUE:   state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SHOW;
      SHOW:    if (step_take) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
    if (!view_en) begin
      state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Index and display latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx      <= 4'd0;
      disp_val <= 16'h0000;
      disp_idx <= 4'd0;
    end else begin
      if (step_take) begin
        idx <= step_fwd ? idx + 4'd1 : idx - 4'd1;
      end
      // The bank has had the whole ISSUE cycle plus SAMPLE to settle on chave.
      if ((state == SAMPLE) && view_en) begin
        disp_val <= valor;
        disp_idx <= idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  logic       idx_ge10;
  logic [3:0] idx_units;

  assign idx_ge10  = (disp_idx >= 4'd10);
  assign idx_units = idx_ge10 ? (disp_idx - 4'd10) : disp_idx;

  always_comb begin
    chave = 6'd0;
    valid = 1'b0;
    hex0  = BLANK;
    hex1  = BLANK;
    hex2  = BLANK;
    hex3  = BLANK;
    hex4  = BLANK;
    hex5  = BLANK;
    case (state)
      ISSUE, SAMPLE: begin
        chave = {2'b00, idx};
      end
      SHOW: begin
        chave = {2'b00, idx};
        valid = 1'b1;
        hex0  = seg7(disp_val[3:0]);
        hex1  = seg7(disp_val[7:4]);
        hex2  = seg7(disp_val[11:8]);
        hex3  = seg7(disp_val[15:12]);
        hex4  = seg7(idx_units);
        hex5  = seg7(idx_ge10 ? 4'd1 : 4'd0);
      end
      default: begin
        chave = 6'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_view_scanner.sv
module tb_reg_view_scanner;

  localparam int DEB  = 4;
  localparam int SDIV = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        view_en;
  logic        key_next;
  logic        key_prev;
  logic        auto_sw;
  logic [5:0]  chave;
  logic [15:0] valor;
  logic        valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] regmem [16];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [47:0] exp_q [$];
  logic [47:0] obs_q [$];
  int          obs_t [$];
  logic [3:0]  model_idx = 4'd0;
  logic        valid_d = 1'b0;

  always #5 clock = ~clock;

  // Bank model: combinational read of chave.
  assign valor = regmem[chave[3:0]];

  reg_view_scanner #(.DEBOUNCE(DEB), .SCAN_DIV(SDIV)) dut (
    .clock(clock), .reset(reset), .view_en(view_en),
    .key_next(key_next), .key_prev(key_prev), .auto_sw(auto_sw),
    .chave(chave), .valor(valor), .valid(valid),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  // Monitor: every rising valid is one produced display frame.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (valid && !valid_d) begin
      obs_q.push_back({chave, hex5, hex4, hex3, hex2, hex1, hex0});
      obs_t.push_back(cyc);
    end
    valid_d = valid;
  end

  function automatic logic [47:0] exp_vec(input logic [3:0] i);
    logic [15:0] v;
    logic [3:0]  u;
    v = regmem[i];
    u = (i >= 4'd10) ? (i - 4'd10) : i;
    return {2'b00, i, seg_tab[(i >= 4'd10) ? 1 : 0], seg_tab[u],
            seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
  endfunction

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (obs_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic press(input bit nxt, input bit prv, input int low_cycles);
    @(negedge clock);
    key_next = ~nxt;
    key_prev = ~prv;
    repeat (low_cycles) @(negedge clock);
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (DEB + 8) @(negedge clock);
  endtask

  task automatic test_reset;
    bit ok;
    int n;
    logic [47:0] e, o;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (chave !== 6'd0) begin fails++; $display("FAIL reset_chave got %h want 00", chave); end
    checks++;
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++;
    if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'h7F}}) begin
      fails++; $display("FAIL reset_hex got %h want all 7F", {hex5, hex4, hex3, hex2, hex1, hex0});
    end
    exp_q.push_back(exp_vec(4'd0));
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!valid && n < 10);
    checks++;
    if (n !== 3) begin fails++; $display("FAIL reset_latency got %0d edges want 3", n); end
    checks++;
    if ({hex3, hex2, hex1, hex0, hex5, hex4} !== {7'h03, 7'h06, 7'h06, 7'h0E, 7'h40, 7'h40}) begin
      fails++; $display("FAIL beef_digits got %h want 03 06 06 0E 40 40",
                        {hex3, hex2, hex1, hex0, hex5, hex4});
    end
    wait_obs(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL reset_frame got timeout want frame");
    end else begin
      o = obs_q.pop_front(); void'(obs_t.pop_front()); e = exp_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL reset_frame got %h want %h", o, e); end
    end
  endtask

  task automatic test_debounce;
    bit ok;
    logic [47:0] e, o;
    model_idx = model_idx + 4'd1;
    exp_q.push_back(exp_vec(model_idx));
    press(1'b1, 1'b0, 20);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL debounce_step got timeout want frame");
    end else begin
      o = obs_q.pop_front(); void'(obs_t.pop_front()); e = exp_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL debounce_step got %h want %h", o, e); end
    end
    repeat (10) @(negedge clock);
    checks++;
    if (obs_q.size() !== 0) begin
      fails++; $display("FAIL debounce_single got %0d extra frames want 0", obs_q.size());
    end
    press(1'b1, 1'b0, 3);
    repeat (10) @(negedge clock);
    checks++;
    if ({obs_q.size() == 0, valid, chave} !== {1'b1, 1'b1, 6'd1}) begin
      fails++; $display("FAIL glitch_ignored got frames=%0d valid=%b chave=%0d want 0 1 1",
                        obs_q.size(), valid, chave);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [47:0] e, o;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) model_idx = model_idx - 4'd1;
      else       model_idx = model_idx + 4'd1;
      exp_q.push_back(exp_vec(model_idx));
      press(k == 2, k < 2, 20);
      wait_obs(ok);
      checks++;
      if (!ok) begin
        fails++; $display("FAIL wrap_%0d got timeout want frame", k);
      end else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front()); e = exp_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL wrap_%0d got %h want %h", k, o, e); end
      end
      if (k == 1) begin
        checks++;
        if ({chave, hex5, hex4} !== {6'd15, 7'h79, 7'h12}) begin
          fails++; $display("FAIL wrap_to_15 got %h want 0f 79 12", {chave, hex5, hex4});
        end
      end
      if (k == 2) begin
        checks++;
        if ({chave, hex5, hex4} !== {6'd0, 7'h40, 7'h40}) begin
          fails++; $display("FAIL wrap_to_0 got %h want 00 40 40", {chave, hex5, hex4});
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    bit dropped = 1'b0;
    @(negedge clock);
    key_next = 1'b0;
    key_prev = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (!valid) dropped = 1'b1;
    end
    key_next = 1'b1;
    key_prev = 1'b1;
    for (int n = 0; n < DEB + 8; n++) begin
      @(negedge clock);
      if (!valid) dropped = 1'b1;
    end
    checks++;
    if ({dropped, chave, obs_q.size() == 0} !== {1'b0, 2'b00, model_idx, 1'b1}) begin
      fails++; $display("FAIL both_keys got dropped=%b chave=%0d frames=%0d want 0 %0d 0",
                        dropped, chave, obs_q.size(), model_idx);
    end
  endtask

  task automatic test_view_drop;
    bit ok;
    int n;
    logic [47:0] e, o;
    model_idx = model_idx + 4'd1;
    exp_q.push_back(exp_vec(model_idx));
    press(1'b1, 1'b0, 20);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL pre_drop_step got timeout want frame");
    end else begin
      o = obs_q.pop_front(); void'(obs_t.pop_front()); e = exp_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL pre_drop_step got %h want %h", o, e); end
    end
    view_en = 1'b0;             // SHOW -> IDLE
    @(negedge clock);
    view_en = 1'b1;             // IDLE -> ISSUE
    @(negedge clock);           // ISSUE -> SAMPLE on the next edge
    @(negedge clock);
    view_en = 1'b0;             // now in SAMPLE
    @(negedge clock);
    checks++;
    if ({valid, chave, hex5, hex4, hex3, hex2, hex1, hex0} !== {1'b0, 6'd0, {6{7'h7F}}}) begin
      fails++; $display("FAIL sample_drop got valid=%b chave=%0d hex=%h want 0 0 blank",
                        valid, chave, {hex5, hex4, hex3, hex2, hex1, hex0});
    end
    exp_q.push_back(exp_vec(model_idx));
    view_en = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!valid && n < 10);
    checks++;
    if (n !== 3) begin fails++; $display("FAIL reraise_latency got %0d edges want 3", n); end
    wait_obs(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL reraise_frame got timeout want frame");
    end else begin
      o = obs_q.pop_front(); void'(obs_t.pop_front()); e = exp_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL reraise_frame got %h want %h", o, e); end
    end
  endtask

`ifdef REG_VIEW_AUTOSCAN_EN
  task automatic test_autoscan;
    bit ok;
    int t, t_prev;
    logic [47:0] e, o;
    @(negedge clock);
    auto_sw  = 1'b1;
    key_prev = 1'b0;            // held through the scan; must have no effect
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      model_idx = model_idx + 4'd1;
      exp_q.push_back(exp_vec(model_idx));
      wait_obs(ok);
      checks++;
      if (!ok) begin
        fails++; $display("FAIL autoscan_%0d got timeout want frame", k);
      end else begin
        o = obs_q.pop_front(); t = obs_t.pop_front(); e = exp_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL autoscan_%0d got %h want %h", k, o, e); end
        if (k > 0) begin
          checks++;
          if (t - t_prev !== SDIV + 2) begin
            fails++; $display("FAIL autoscan_period got %0d want %0d", t - t_prev, SDIV + 2);
          end
        end
        t_prev = t;
      end
    end
    auto_sw  = 1'b0;
    key_prev = 1'b1;
    repeat (DEB + 8) @(negedge clock);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) regmem[i] = 16'($urandom);
    regmem[0] = 16'hBEEF;
    reset    = 1'b0;
    view_en  = 1'b1;
    key_next = 1'b1;
    key_prev = 1'b1;
    auto_sw  = 1'b0;

    test_reset();
    test_debounce();
    test_wrap();
    test_simultaneous();
    test_view_drop();
`ifdef REG_VIEW_AUTOSCAN_EN
    test_autoscan();
`endif

    repeat (5) @(negedge clock);
    checks++;
    if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
      fails++; $display("FAIL scoreboard_drain got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
